// File: rtl/dmem_responder_if.sv
// Data-memory request interface between the pipeline MEM stage (master)
// and the multi-cycle responder (slave).
interface dmem_responder_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        valid;
   logic        stall;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, valid, stall
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, valid, stall
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: fixed-latency backing store that freezes
// the MEM stage with stall until the single outstanding access completes.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access in flight; stall follows enable, request captured on enable
// BUSY  | latency countdown running; access performed when counter reaches 1
// DONE  | one-cycle valid pulse; enable ignored (old request still presented)
module dmem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
   // With a latency of one the access happens on the accept edge itself,
   // straight from the bus, because there is no BUSY cycle to do it in.
   localparam bit SINGLE = (LATENCY == 1);

   state_t                state_q,    state_d;
   logic [3:0]            cnt_q,      cnt_d;
   logic                  req_wr_q,   req_wr_d;
   logic [DEPTH_LOG2-1:0] req_idx_q,  req_idx_d;
   logic [15:0]           req_data_q, req_data_d;
   logic [15:0]           data_out_q, data_out_d;
   logic                  valid_q,    valid_d;

   logic [15:0]           mem [2**DEPTH_LOG2];

   logic                  acc_go;
   logic                  acc_wr;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [15:0]           acc_data;

   // Upper address bits alias onto the word array.
   logic addr_unused;
   assign addr_unused = ^bus.addr[15:DEPTH_LOG2];

   // Select where the array access takes its operands from and when it fires.
   always_comb begin
      acc_go   = 1'b0;
      acc_wr   = req_wr_q;
      acc_idx  = req_idx_q;
      acc_data = req_data_q;
      if (SINGLE) begin
         acc_wr   = bus.wr;
         acc_idx  = bus.addr[DEPTH_LOG2-1:0];
         acc_data = bus.data_in;
         acc_go   = rst_n && (state_q == IDLE) && bus.enable;
      end else begin
         acc_go   = rst_n && (state_q == BUSY) && (cnt_q == 4'd1);
      end
   end

   // Next-state, request capture and read-data update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_wr_d   = req_wr_q;
      req_idx_d  = req_idx_q;
      req_data_d = req_data_q;
      data_out_d = data_out_q;
      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               req_wr_d   = bus.wr;
               req_idx_d  = bus.addr[DEPTH_LOG2-1:0];
               req_data_d = bus.data_in;
               if (SINGLE) begin
                  state_d = DONE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (acc_go && !acc_wr) begin
         data_out_d = mem[acc_idx];
      end
      valid_d = (state_d == DONE);
   end

   // FSM and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         req_wr_q   <= 1'b0;
         req_idx_q  <= '0;
         req_data_q <= 16'h0000;
         data_out_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_wr_q   <= req_wr_d;
         req_idx_q  <= req_idx_d;
         req_data_q <= req_data_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
      end
   end

   // Backing store write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (acc_go && acc_wr) begin
         mem[acc_idx] <= acc_data;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.valid    = valid_q;
   assign bus.stall    = rst_n && (((state_q == IDLE) && bus.enable) || (state_q == BUSY));

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the CPU's data-memory request interface (enable / wr / addr / data_in in, data_out back).
- Replaces the single-cycle data memory for the 5-stage pipeline.
- Models a fixed-latency backing store and tells the pipeline to freeze the MEM stage via `stall` until the access completes.
- One access outstanding at a time; completion is signalled with a one-cycle `valid` pulse.

Parameters:
- DEPTH_LOG2, 10: word-array depth is 2**DEPTH_LOG2 16-bit words; word index = addr[DEPTH_LOG2-1:0], upper addr bits ignored (aliasing).
- LATENCY, 4: cycles from request acceptance to completion, legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  request present; initiator holds enable/wr/addr/data_in stable while stall=1
- wr  in  1  1=write, 0=read; sampled with enable
- addr  in  16  word address
- data_in  in  16  write data
- data_out  out  16  read data; valid from the `valid` cycle until the next read completes
- valid  out  1  one-cycle completion pulse (reads and writes)
- stall  out  1  initiator must hold the request and freeze upstream while high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, data_out=16'h0000, valid=0, stall=0 (forced low during reset regardless of enable).
  - Array contents are not cleared; they are undefined until written.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = enable (combinational), valid=0.
  - If enable=1 at the rising edge: capture wr/addr/data_in into request registers (the "accept edge").
  - Next state is BUSY with counter=LATENCY-1 if LATENCY>1, else DONE.
- BUSY:
  - stall=1, valid=0, counter decrements each edge.
  - When counter==1 at the edge: go to DONE and perform the access using the captured request.
  - Read: data_out <= mem[idx].
  - Write: mem[idx] <= captured data; data_out unchanged.
- DONE:
  - valid=1, stall=0 for exactly one cycle; the initiator advances at the end of this cycle.
  - enable is ignored in DONE, because the completed request is still being presented.
  - Next state is always IDLE.
- Timing: the accept edge ends cycle 0; valid=1 in cycle LATENCY. Minimum back-to-back spacing is LATENCY+1 cycles (DONE then IDLE).
- Inputs are sampled only at the accept edge. Changes while stall=1 are a protocol violation and have no effect.
- Write-then-read to the same address returns the new data, because the write commits before the read is accepted.
- A read of an address with no prior write returns X. The bench writes before reading.
- rst_n asserted mid-access aborts the access: a pending write is discarded, the array is untouched, and outputs return to reset values immediately.
- enable deasserted in IDLE: no state change, stall=0.
- Counter is 4 bits.

Test Plan:
1. LATENCY=4: in IDLE, drive enable=1, wr=1, addr=16'h0010, data_in=16'hBEEF.
   - stall=1 for cycles 0-3, valid=1 in cycle 4 only, data_out stays 16'h0000.
2. Follow-up read addr=16'h0010.
   - valid in cycle 4 after accept, data_out=16'hBEEF, held through later writes until the next read completes.
3. Aliasing with DEPTH_LOG2=8: write 16'h1234 to addr 16'h0105, then read addr 16'h0005.
   - data_out=16'h1234.
4. Hold enable=1 continuously with two queued requests.
   - Exactly one acceptance per LATENCY+1 cycles.
   - DONE cycle does not re-accept.
   - The second request is accepted in the following IDLE cycle.
5. Reset mid-access: assert rst_n=0 during BUSY of a write of 16'hAAAA to addr 5 (previously 16'h5555), release, read addr 5.
   - During reset: valid=0, stall=0, data_out=0.
   - Read returns 16'h5555.
6. LATENCY=1 build: read request.
   - stall=1 in cycle 0 only, valid=1 in cycle 1, no BUSY state visited.
